// File: rtl/cgra_seq_pkg.sv
// Purpose: shared types and constants for the CGRA configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cgra_seq_pkg;

   // Sequencer phases: load config, idle settle gap, driven run window, finished.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONFIG = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_t;

   // Per-channel stimulus modes.
   localparam logic STIM_HOLD = 1'b0;
   localparam logic STIM_INC  = 1'b1;

   // Address 0 is a no-op on the CGRA config bus.
   localparam int CFG_NOP_ADDR = 0;

endpackage

// File: rtl/cgra_stim_channel.sv
// Purpose: one pad stimulus channel register with load / hold / increment.
// Latency: new value visible one cycle after load or increment.
// Backpressure: none; clear beats load beats increment.
module cgra_stim_channel #(
   parameter int CH_W = 16
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            i_clr,
   input  logic            i_load,
   input  logic            i_inc,
   input  logic [CH_W-1:0] i_seed,
   output logic [CH_W-1:0] o_val
);

   logic [CH_W-1:0] r_val;

   // Stimulus register; increment wraps modulo 2^CH_W.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in)   r_val <= '0;
      else if (i_clr)  r_val <= '0;
      else if (i_load) r_val <= i_seed;
      else if (i_inc)  r_val <= r_val + CH_W'(1);
   end

   assign o_val = r_val;

endmodule

// File: rtl/cgra_config_sequencer.sv
// Purpose: replays host config words onto the CGRA config bus, then drives pads for a run window and captures pad outputs.
// Latency: accepted word appears on config outputs 1 cycle later; pad stimulus to capture is 1 cycle.
// Backpressure: cfg_ready_out high only in IDLE/CONFIG; no stall during RUN, captures are never held off.
module cgra_config_sequencer
   import cgra_seq_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int CH_W   = 16,
   parameter int CNT_W  = 16
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   cfg_valid_in,
   output logic                   cfg_ready_out,
   input  logic [ADDR_W-1:0]      cfg_addr_in,
   input  logic [DATA_W-1:0]      cfg_data_in,
   input  logic                   cfg_last_in,
   input  logic [CNT_W-1:0]       settle_cycles_in,
   input  logic [CNT_W-1:0]       run_cycles_in,
   input  logic [NUM_CH*CH_W-1:0] stim_seed_in,
   input  logic [NUM_CH-1:0]      stim_mode_in,
   input  logic                   abort_in,
   output logic [ADDR_W-1:0]      config_addr_out,
   output logic [DATA_W-1:0]      config_data_out,
   output logic [NUM_CH*CH_W-1:0] pad_in_out,
   input  logic [NUM_CH*CH_W-1:0] pad_out_in,
   output logic                   capt_valid_out,
   output logic [NUM_CH*CH_W-1:0] capt_data_out,
   output logic [CNT_W-1:0]       capt_cycle_out,
   output logic                   busy_out,
   output logic                   done_out
);

   seq_state_t              r_state;
   seq_state_t              w_state_nxt;
   logic                    r_cfg_rdy;
   logic [ADDR_W-1:0]       r_cfg_addr;
   logic [DATA_W-1:0]       r_cfg_data;
   logic [CNT_W-1:0]        r_settle_cnt;
   logic [CNT_W-1:0]        r_run_len;
   logic [CNT_W-1:0]        r_run_idx;
   logic                    r_capt_vld;
   logic [NUM_CH*CH_W-1:0]  r_capt_dat;
   logic [CNT_W-1:0]        r_capt_cyc;
   logic                    w_accept;
   logic                    w_accept_last;
   logic                    w_load;
   logic                    w_run_step;
   logic                    w_last_idx;
   logic [NUM_CH-1:0]       w_inc;

   // Abort wins over a simultaneous accept.
   assign w_accept      = cfg_valid_in & r_cfg_rdy & ~abort_in;
   assign w_accept_last = w_accept & cfg_last_in;
   assign w_last_idx    = (r_run_idx == r_run_len - CNT_W'(1));

   // State register.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state and run-window control.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_run_step  = 1'b0;
      w_inc       = '0;
      case (r_state)
         ST_IDLE, ST_CONFIG: begin
            if (w_accept) begin
               if (!cfg_last_in) begin
                  w_state_nxt = ST_CONFIG;
               end else if (settle_cycles_in == '0) begin
                  w_state_nxt = ST_RUN;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (r_settle_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end
         end
         ST_RUN: begin
            if (r_run_len == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_run_step = 1'b1;
               if (w_last_idx) w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
      // Last run cycle does not advance, so pads hold the final stimulus in DONE.
      for (int i = 0; i < NUM_CH; i++) begin
         w_inc[i] = w_run_step && !w_last_idx && (stim_mode_in[i] == STIM_INC);
      end
      if (abort_in) begin
         w_state_nxt = ST_IDLE;
         w_load      = 1'b0;
         w_run_step  = 1'b0;
         w_inc       = '0;
      end
   end

   // Ready follows the upcoming state so it drops on the same edge as the last accept.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) r_cfg_rdy <= 1'b0;
      else           r_cfg_rdy <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_CONFIG);
   end

   // Config bus: one-cycle pulse per accepted word, no-op otherwise.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_cfg_addr <= '0;
         r_cfg_data <= '0;
      end else if (w_accept) begin
         r_cfg_addr <= cfg_addr_in;
         r_cfg_data <= cfg_data_in;
      end else begin
         r_cfg_addr <= ADDR_W'(CFG_NOP_ADDR);
         r_cfg_data <= '0;
      end
   end

   // Settle down-counter, run length latch and run cycle index.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_settle_cnt <= '0;
         r_run_len    <= '0;
         r_run_idx    <= '0;
      end else if (abort_in) begin
         r_settle_cnt <= '0;
         r_run_len    <= '0;
         r_run_idx    <= '0;
      end else if (w_accept_last) begin
         r_settle_cnt <= settle_cycles_in;
         r_run_len    <= run_cycles_in;
         r_run_idx    <= '0;
      end else if (r_state == ST_SETTLE) begin
         r_settle_cnt <= r_settle_cnt - CNT_W'(1);
      end else if (w_run_step) begin
         r_run_idx <= r_run_idx + CNT_W'(1);
      end
   end

   // Capture of pad outputs for each run cycle.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_capt_vld <= 1'b0;
         r_capt_dat <= '0;
         r_capt_cyc <= '0;
      end else if (abort_in) begin
         r_capt_vld <= 1'b0;
         r_capt_dat <= '0;
         r_capt_cyc <= '0;
      end else begin
         r_capt_vld <= w_run_step;
         if (w_run_step) begin
            r_capt_dat <= pad_out_in;
            r_capt_cyc <= r_run_idx;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cgra_stim_channel #(.CH_W(CH_W)) u_ch (
         .clk_in   (clk_in),
         .reset_in (reset_in),
         .i_clr    (abort_in),
         .i_load   (w_load),
         .i_inc    (w_inc[g]),
         .i_seed   (stim_seed_in[g*CH_W +: CH_W]),
         .o_val    (pad_in_out[g*CH_W +: CH_W])
      );
   end

   assign cfg_ready_out   = r_cfg_rdy;
   assign config_addr_out = r_cfg_addr;
   assign config_data_out = r_cfg_data;
   assign capt_valid_out  = r_capt_vld;
   assign capt_data_out   = r_capt_dat;
   assign capt_cycle_out  = r_capt_cyc;
   assign busy_out        = (r_state == ST_CONFIG) || (r_state == ST_SETTLE) || (r_state == ST_RUN);
   assign done_out        = (r_state == ST_DONE);

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Purpose: scoreboard bench for cgra_config_sequencer with directed and random streams.
// Latency: expectations are stamped with the cycle they must appear in.
// Backpressure: words are only offered when the reference model expects ready.
module tb_cgra_config_sequencer;

   localparam int INF = 32'h7fff_ffff;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        cfg_valid_in, cfg_ready_out, cfg_last_in, abort_in;
   logic [31:0] cfg_addr_in, cfg_data_in, config_addr_out, config_data_out;
   logic [15:0] settle_cycles_in, run_cycles_in, capt_cycle_out;
   logic [63:0] stim_seed_in, pad_in_out, pad_out_in, capt_data_out;
   logic [3:0]  stim_mode_in;
   logic        capt_valid_out, busy_out, done_out;
   logic [63:0] lb_xor;

   assign pad_out_in = pad_in_out ^ lb_xor;

   cgra_config_sequencer #(.ADDR_W(32), .DATA_W(32), .NUM_CH(4), .CH_W(16), .CNT_W(16)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
      .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in),
      .settle_cycles_in(settle_cycles_in), .run_cycles_in(run_cycles_in), .stim_seed_in(stim_seed_in),
      .stim_mode_in(stim_mode_in), .abort_in(abort_in), .config_addr_out(config_addr_out),
      .config_data_out(config_data_out), .pad_in_out(pad_in_out), .pad_out_in(pad_out_in),
      .capt_valid_out(capt_valid_out), .capt_data_out(capt_data_out), .capt_cycle_out(capt_cycle_out),
      .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct { int stamp; logic [31:0] a; logic [31:0] d; } cfg_exp_t;
   typedef struct { int stamp; logic [63:0] d; logic [15:0] k; } cap_exp_t;
   cfg_exp_t cq[$];
   cap_exp_t capq[$];

   int n_checks = 0, n_errors = 0;
   int busy_from = 0, busy_to = 0, done_from = 0, done_to = 0, nrdy_from = 0, nrdy_to = 0;
   bit mon_en = 0, rdy_chk = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit inwin(input int c, input int f, input int t);
      return (c >= f) && (c < t);
   endfunction

   // Reference stimulus: per channel seed (hold) or seed + k modulo 2^16 (increment).
   function automatic logic [63:0] stim(input logic [63:0] seed, input logic [3:0] mode, input int k);
      logic [63:0] r;
      logic [15:0] s;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         s = seed[c*16 +: 16];
         r[c*16 +: 16] = mode[c] ? 16'(int'(s) + k) : s;
      end
      return r;
   endfunction

   // Monitor: compares DUT outputs against stamped expectations every cycle.
   always @(negedge clk_in) begin
      if (mon_en) begin
         if (cq.size() > 0 && cq[0].stamp == cyc) begin
            check("cfg_addr", config_addr_out, cq[0].a);
            check("cfg_data", config_data_out, cq[0].d);
            void'(cq.pop_front());
         end else begin
            check("cfg_addr_nop", config_addr_out, 0);
            check("cfg_data_nop", config_data_out, 0);
         end
         if (capq.size() > 0 && capq[0].stamp == cyc) begin
            check("capt_valid", capt_valid_out, 1);
            check("capt_data", capt_data_out, capq[0].d);
            check("capt_cycle", capt_cycle_out, capq[0].k);
            void'(capq.pop_front());
         end else begin
            check("capt_valid_idle", capt_valid_out, 0);
         end
         check("busy", busy_out, inwin(cyc, busy_from, busy_to));
         check("done", done_out, inwin(cyc, done_from, done_to));
         if (rdy_chk) check("cfg_ready", cfg_ready_out, !inwin(cyc, nrdy_from, nrdy_to));
      end
   end

   task automatic step();
      @(negedge clk_in);
      #1;
   endtask

   task automatic clip_windows(input int t);
      if (busy_to > t) busy_to = t;
      if (done_to > t) done_to = t;
      if (nrdy_to > t) nrdy_to = t;
   endtask

   task automatic send_stream(input int n, input int gmin, input int gmax, input bit with_last, input bit directed,
                              input logic [15:0] st, input logic [15:0] rn, input logic [63:0] seed,
                              input logic [3:0] mode, output int last_edge, output int done_at);
      logic [31:0] a, d;
      int gap;
      last_edge = -1;
      done_at   = -1;
      settle_cycles_in = st;
      run_cycles_in    = rn;
      stim_seed_in     = seed;
      stim_mode_in     = mode;
      for (int i = 0; i < n; i++) begin
         cfg_valid_in = 1'b0;
         gap = $urandom_range(gmax, gmin);
         repeat (gap) step();
         if (directed) begin
            a = 32'h10 * (i + 1);
            d = 32'hA + i;
         end else begin
            a = $urandom;
            if (a == 0) a = 32'h1;
            d = $urandom;
         end
         cfg_valid_in = 1'b1;
         cfg_addr_in  = a;
         cfg_data_in  = d;
         cfg_last_in  = with_last && (i == n - 1);
         check("ready_at_send", cfg_ready_out, 1);
         cq.push_back('{cyc + 1, a, d});
         if (i == 0) begin
            busy_from = cyc + 1;
            busy_to   = INF;
         end
         if (cfg_last_in) begin
            last_edge = cyc + 1;
            for (int k = 0; k < int'(rn); k++)
               capq.push_back('{last_edge + int'(st) + k + 1, stim(seed, mode, k) ^ lb_xor, 16'(k)});
            done_at   = (rn > 0) ? last_edge + int'(st) + int'(rn) : last_edge + int'(st) + 1;
            busy_to   = done_at;
            done_from = done_at;
            done_to   = INF;
            nrdy_from = last_edge;
            nrdy_to   = INF;
         end
         step();
      end
      cfg_valid_in = 1'b0;
      cfg_last_in  = 1'b0;
   endtask

   task automatic do_abort(input bit with_valid);
      cfg_valid_in = with_valid;
      cfg_addr_in  = 32'h77;
      cfg_data_in  = 32'h99;
      cfg_last_in  = with_valid;
      abort_in     = 1'b1;
      cq.delete();
      capq.delete();
      clip_windows(cyc + 1);
      step();
      abort_in     = 1'b0;
      cfg_valid_in = 1'b0;
      cfg_last_in  = 1'b0;
      check("abort_pad", pad_in_out, 0);
      check("abort_capt_data", capt_data_out, 0);
      check("abort_capt_cycle", capt_cycle_out, 0);
      check("abort_ready", cfg_ready_out, 1);
      check("abort_busy", busy_out, 0);
   endtask

   task automatic do_reset_midcycle();
      cfg_valid_in = 1'b0;
      @(posedge clk_in);
      #2;
      reset_in = 1'b0;
      #1;
      check("rst_cfg_addr", config_addr_out, 0);
      check("rst_cfg_data", config_data_out, 0);
      check("rst_ready", cfg_ready_out, 0);
      check("rst_capt", {capt_valid_out, capt_cycle_out}, 0);
      check("rst_pad", pad_in_out, 0);
      check("rst_busy_done", {busy_out, done_out}, 0);
      cq.delete();
      capq.delete();
      clip_windows(cyc);
      rdy_chk = 0;
      repeat (2) step();
      reset_in = 1'b1;
      step();
      check("ready_after_reset", cfg_ready_out, 1);
      rdy_chk = 1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not complete (checks %0d, errors %0d)", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int le, da;
      logic [63:0] seed;
      reset_in = 1'b1; cfg_valid_in = 0; cfg_last_in = 0; abort_in = 0;
      cfg_addr_in = 0; cfg_data_in = 0; settle_cycles_in = 0; run_cycles_in = 0;
      stim_seed_in = 0; stim_mode_in = 0; lb_xor = 0;
      #1 reset_in = 1'b0;
      #1;
      check("reset_outputs", {config_addr_out, config_data_out}, 0);
      check("reset_misc", {cfg_ready_out, capt_valid_out, busy_out, done_out, capt_cycle_out}, 0);
      check("reset_pad", pad_in_out, 0);
      repeat (3) step();
      reset_in = 1'b1;
      repeat (2) step();
      mon_en  = 1;
      rdy_chk = 1;
      check("ready_idle", cfg_ready_out, 1);

      // Back-to-back stream, settle 2, run 4, loopback pads, wrap on channel 1.
      seed = 64'h0000_0007_FFFE_0003;
      send_stream(3, 0, 0, 1, 1, 16'd2, 16'd4, seed, 4'b1010, le, da);
      while (cyc < da + 2) step();
      cfg_valid_in = 1'b1;
      cfg_addr_in  = 32'h55;
      cfg_data_in  = 32'h66;
      repeat (2) step();
      cfg_valid_in = 1'b0;
      check("pad_hold_done", pad_in_out, 64'h0003_0007_0001_0003);
      do_abort(0);

      // Gapped stream, settle 0 and run 0: straight through RUN to DONE, no captures.
      seed = {$urandom, $urandom};
      send_stream(3, 1, 1, 1, 0, 16'd0, 16'd0, seed, 4'b1111, le, da);
      while (cyc < da + 2) step();
      check("pad_seed_run0", pad_in_out, seed);
      do_abort(0);
      do_abort(1);

      // Abort while in RUN cycle 2.
      lb_xor = 64'h0123_4567_89AB_CDEF;
      seed = {$urandom, $urandom};
      send_stream(1, 0, 0, 1, 0, 16'd1, 16'd6, seed, 4'b0110, le, da);
      while (cyc < le + 1 + 2) step();
      do_abort(0);

      // Asynchronous reset in the middle of a config stream.
      send_stream(2, 0, 1, 0, 0, 16'd0, 16'd0, seed, 4'b0000, le, da);
      do_reset_midcycle();
      send_stream(1, 0, 0, 1, 0, 16'd0, 16'd2, seed, 4'b0001, le, da);
      while (cyc < da + 1) step();
      do_abort(0);

      // Randomized streams.
      for (int it = 0; it < 20; it++) begin
         lb_xor = {$urandom, $urandom};
         seed   = {$urandom, $urandom};
         send_stream($urandom_range(4, 1), 0, 2, 1, 0, 16'($urandom_range(3, 0)),
                     16'($urandom_range(6, 0)), seed, 4'($urandom), le, da);
         while (cyc < da + int'($urandom_range(2, 0))) step();
         do_abort(0);
      end

      step();
      check("cfg_queue_drained", cq.size(), 0);
      check("capt_queue_drained", capq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
